// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE loop sequencer: FSM state encoding and default widths.
package pe_ctrl_pkg;

  localparam int ACTV_ADDR_BW_DEF = 2;
  localparam int WGT_ADDR_BW_DEF  = 2;
  localparam int PSUM_ADDR_BW_DEF = 2;
  localparam int DRAIN_CYCLES_DEF = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_BUF = 3'd1,
    RUN      = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } state_t;

endpackage

// File: rtl/loop_cnt2.sv
// Nested k/o loop counter: k runs 0..k_max, then wraps and advances o.
// last flags the final (k_max, o_max) iteration.
module loop_cnt2 #(
  parameter int KW = 2,
  parameter int OW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [KW-1:0] k_max,
  input  logic [OW-1:0] o_max,
  output logic [KW-1:0] k,
  output logic [OW-1:0] o,
  output logic          k_wrap,
  output logic          last
);

  assign k_wrap = (k == k_max);
  assign last   = k_wrap && (o == o_max);

  // k/o iteration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k <= {KW{1'b0}};
      o <= {OW{1'b0}};
    end else if (clr) begin
      k <= {KW{1'b0}};
      o <= {OW{1'b0}};
    end else if (en) begin
      if (k_wrap) begin
        k <= {KW{1'b0}};
        o <= (o == o_max) ? {OW{1'b0}} : o + OW'(1);
      end else begin
        k <= k + KW'(1);
        o <= o;
      end
    end else begin
      k <= k;
      o <= o;
    end
  end

endmodule

// File: rtl/pe_loop_ctrl.sv
// Per-PE loop sequencer: waits for a loaded bank, runs k-inside-o MACs, drains, releases the bank.
// Optional ACC_CLR_EN adds acc_clr, high on every RUN cycle with k == 0.
module pe_loop_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int ACTV_ADDR_BITWIDTH = ACTV_ADDR_BW_DEF,
  parameter int WGT_ADDR_BITWIDTH  = WGT_ADDR_BW_DEF,
  parameter int PSUM_ADDR_BITWIDTH = PSUM_ADDR_BW_DEF,
  parameter int DRAIN_CYCLES       = DRAIN_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ACTV_ADDR_BITWIDTH:0]   cfg_k,
  input  logic [PSUM_ADDR_BITWIDTH:0]   cfg_o,
  input  logic                          buf_valid,
  output logic                          MAC_en,
  output logic                          rd_bank,
  output logic [ACTV_ADDR_BITWIDTH-1:0] actv_r_addr,
  output logic [WGT_ADDR_BITWIDTH-1:0]  wgt_r_addr,
  output logic                          psum_en,
  output logic [PSUM_ADDR_BITWIDTH-1:0] psum_addr,
  output logic [PSUM_ADDR_BITWIDTH-1:0] psum_write_addr,
  output logic                          busy,
  output logic                          buf_release,
`ifdef ACC_CLR_EN
  output logic                          acc_clr,
`endif
  output logic                          done
);

  localparam int AW = ACTV_ADDR_BITWIDTH;
  localparam int PW = PSUM_ADDR_BITWIDTH;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_t          state_r;
  state_t          state_s;
  logic [AW-1:0]   k_max_r;
  logic [PW-1:0]   o_max_r;
  logic [DW-1:0]   drain_cnt_r;
  logic [AW-1:0]   k_s;
  logic [PW-1:0]   o_s;
  logic            k_wrap_s;
  logic            last_s;
  logic            cfg_ok_s;
  logic            drain_last_s;
  logic            cnt_clr_s;
  logic            cnt_en_s;

  assign cfg_ok_s     = start && (cfg_k != {(AW+1){1'b0}}) && (cfg_o != {(PW+1){1'b0}});
  assign drain_last_s = (drain_cnt_r == DW'(DRAIN_CYCLES - 1));
  assign cnt_clr_s    = (state_r == WAIT_BUF) && buf_valid;
  // The counter freezes on the last iteration so addresses hold through DRAIN.
  assign cnt_en_s     = (state_r == RUN) && !last_s;

  loop_cnt2 #(
    .KW (AW),
    .OW (PW)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (cnt_clr_s),
    .en     (cnt_en_s),
    .k_max  (k_max_r),
    .o_max  (o_max_r),
    .k      (k_s),
    .o      (o_s),
    .k_wrap (k_wrap_s),
    .last   (last_s)
  );

  assign actv_r_addr     = k_s;
  assign wgt_r_addr      = WGT_ADDR_BITWIDTH'(k_s);
  assign psum_addr       = o_s;
  assign psum_write_addr = o_s;

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:     if (cfg_ok_s)     state_s = WAIT_BUF; else state_s = IDLE;
      WAIT_BUF: if (buf_valid)    state_s = RUN;      else state_s = WAIT_BUF;
      RUN:      if (last_s)       state_s = DRAIN;    else state_s = RUN;
      DRAIN:    if (drain_last_s) state_s = DONE;     else state_s = DRAIN;
      DONE:     state_s = IDLE;
      default:  state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Tile configuration, stored as terminal counts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_max_r <= {AW{1'b0}};
      o_max_r <= {PW{1'b0}};
    end else if ((state_r == IDLE) && cfg_ok_s) begin
      k_max_r <= AW'(cfg_k - (AW+1)'(1));
      o_max_r <= PW'(cfg_o - (PW+1)'(1));
    end else begin
      k_max_r <= k_max_r;
      o_max_r <= o_max_r;
    end
  end

  // Drain cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  drain_cnt_r <= {DW{1'b0}};
    else if (state_r == DRAIN)  drain_cnt_r <= drain_cnt_r + DW'(1);
    else                        drain_cnt_r <= {DW{1'b0}};
  end

  // Moore outputs registered from the next state so they align with the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      MAC_en      <= 1'b0;
      psum_en     <= 1'b0;
      busy        <= 1'b0;
      buf_release <= 1'b0;
      done        <= 1'b0;
      rd_bank     <= 1'b0;
    end else begin
      MAC_en      <= (state_s == RUN);
      psum_en     <= (state_s == RUN) || (state_s == DRAIN);
      busy        <= (state_s != IDLE);
      buf_release <= (state_s == DONE);
      done        <= (state_s == DONE);
      rd_bank     <= (state_r == DONE) ? ~rd_bank : rd_bank;
    end
  end

`ifdef ACC_CLR_EN
  // Fresh accumulation whenever the next RUN cycle starts at k == 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_clr <= 1'b0;
    else       acc_clr <= (state_s == RUN) && ((state_r == WAIT_BUF) || k_wrap_s);
  end
`else
  logic unused_s;
  assign unused_s = k_wrap_s;
`endif

endmodule

// File: tb/tb_pe_loop_ctrl.sv
// Self-checking bench for pe_loop_ctrl: directed tiles plus randomized tiles against a tile-level model.
module tb_pe_loop_ctrl;

  localparam int AW = 2;
  localparam int WW = 2;
  localparam int PW = 2;
  localparam int DC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   cfg_k;
  logic [PW:0]   cfg_o;
  logic          buf_valid;
  logic          MAC_en;
  logic          rd_bank;
  logic [AW-1:0] actv_r_addr;
  logic [WW-1:0] wgt_r_addr;
  logic          psum_en;
  logic [PW-1:0] psum_addr;
  logic [PW-1:0] psum_write_addr;
  logic          busy;
  logic          buf_release;
  logic          done;
`ifdef ACC_CLR_EN
  logic          acc_clr;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit exp_bank = 1'b0;

  pe_loop_ctrl #(
    .ACTV_ADDR_BITWIDTH (AW),
    .WGT_ADDR_BITWIDTH  (WW),
    .PSUM_ADDR_BITWIDTH (PW),
    .DRAIN_CYCLES       (DC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .cfg_k           (cfg_k),
    .cfg_o           (cfg_o),
    .buf_valid       (buf_valid),
    .MAC_en          (MAC_en),
    .rd_bank         (rd_bank),
    .actv_r_addr     (actv_r_addr),
    .wgt_r_addr      (wgt_r_addr),
    .psum_en         (psum_en),
    .psum_addr       (psum_addr),
    .psum_write_addr (psum_write_addr),
    .busy            (busy),
    .buf_release     (buf_release),
`ifdef ACC_CLR_EN
    .acc_clr         (acc_clr),
`endif
    .done            (done)
  );

  always #5 clk = ~clk;

  logic [5:0] ctl;
  assign ctl = {busy, MAC_en, psum_en, done, buf_release, rd_bank};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] ctl_exp(input bit b, input bit m, input bit p, input bit d, input bit r);
    return {b, m, p, d, r, exp_bank};
  endfunction

  task automatic check_acc(input string tag, input bit e);
`ifdef ACC_CLR_EN
    check(tag, 32'(acc_clr), 32'(e));
`endif
  endtask

  task automatic check_addr(input string tag, input int k, input int o);
    check({tag, "_actv"}, 32'(actv_r_addr), 32'(k));
    check({tag, "_wgt"}, 32'(wgt_r_addr), 32'(k));
    check({tag, "_psum"}, 32'(psum_addr), 32'(o));
    check({tag, "_pwr"}, 32'(psum_write_addr), 32'(o));
  endtask

  // One tile: kk*oo MAC iterations in k-inner order, after w stalled WAIT_BUF cycles.
  task automatic run_tile(input int kk, input int oo, input int w, input bit start_in_done);
    start = 1'b1; cfg_k = (AW+1)'(kk); cfg_o = (PW+1)'(oo); buf_valid = 1'b0;
    for (int j = 1; j <= w + 1; j++) begin
      @(negedge clk);
      start = 1'b0; cfg_k = (AW+1)'($urandom); cfg_o = (PW+1)'($urandom);
      check("wait_ctl", 32'(ctl), 32'(ctl_exp(1, 0, 0, 0, 0)));
      check_acc("wait_acc", 1'b0);
      buf_valid = (j == w + 1);
    end
    for (int i = 0; i < kk * oo; i++) begin
      @(negedge clk);
      check("run_ctl", 32'(ctl), 32'(ctl_exp(1, 1, 1, 0, 0)));
      check_addr("run", i % kk, i / kk);
      check_acc("run_acc", (i % kk) == 0);
      buf_valid = 1'($urandom_range(0, 1));
    end
    for (int d = 0; d < DC; d++) begin
      @(negedge clk);
      check("drain_ctl", 32'(ctl), 32'(ctl_exp(1, 0, 1, 0, 0)));
      check_addr("drain", kk - 1, oo - 1);
      check_acc("drain_acc", 1'b0);
    end
    @(negedge clk);
    check("done_ctl", 32'(ctl), 32'(ctl_exp(1, 0, 0, 1, 1)));
    check_acc("done_acc", 1'b0);
    if (start_in_done) begin
      start = 1'b1; cfg_k = (AW+1)'(1); cfg_o = (PW+1)'(1);
    end
    exp_bank = ~exp_bank;
    @(negedge clk);
    start = 1'b0;
    check("idle_ctl", 32'(ctl), 32'(ctl_exp(0, 0, 0, 0, 0)));
    @(negedge clk);
    check("idle2_ctl", 32'(ctl), 32'(ctl_exp(0, 0, 0, 0, 0)));
  endtask

  task automatic ignored_start(input int kk, input int oo);
    start = 1'b1; cfg_k = (AW+1)'(kk); cfg_o = (PW+1)'(oo); buf_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_ctl", 32'(ctl), 32'(ctl_exp(0, 0, 0, 0, 0)));
    @(negedge clk);
    check("ign2_ctl", 32'(ctl), 32'(ctl_exp(0, 0, 0, 0, 0)));
  endtask

  task automatic reset_mid_run();
    start = 1'b1; cfg_k = (AW+1)'(3); cfg_o = (PW+1)'(2); buf_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("mr_wait", 32'(ctl), 32'(ctl_exp(1, 0, 0, 0, 0)));
    buf_valid = 1'b1;
    @(negedge clk);
    check_addr("mr_k0", 0, 0);
    @(negedge clk);
    check("mr_run", 32'(ctl), 32'(ctl_exp(1, 1, 1, 0, 0)));
    check_addr("mr_k1", 1, 0);
    #2 reset = 1'b1;
    exp_bank = 1'b0;
    #1;
    check("mr_async_ctl", 32'(ctl), 32'(ctl_exp(0, 0, 0, 0, 0)));
    check_addr("mr_async", 0, 0);
    check_acc("mr_async_acc", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("mr_after", 32'(ctl), 32'(ctl_exp(0, 0, 0, 0, 0)));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; buf_valid = 1'b0;
    cfg_k = (AW+1)'(0); cfg_o = (PW+1)'(0);
    repeat (2) @(negedge clk);
    check("rst_ctl", 32'(ctl), 32'(ctl_exp(0, 0, 0, 0, 0)));
    check_addr("rst", 0, 0);
    check_acc("rst_acc", 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ctl", 32'(ctl), 32'(ctl_exp(0, 0, 0, 0, 0)));

    run_tile(3, 2, 0, 1'b0);
    run_tile(2, 2, 5, 1'b0);
    run_tile(4, 4, 1, 1'b0);
    run_tile(1, 1, 0, 1'b0);
    ignored_start(0, 2);
    ignored_start(3, 0);
    run_tile(2, 1, 0, 1'b1);
    run_tile(2, 1, 0, 1'b0);
    reset_mid_run();
    run_tile(2, 2, 0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 4) == 0)
        ignored_start($urandom_range(0, 1) * $urandom_range(1, 4), 0);
      else
        run_tile($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
